// File: rtl/mpsoc_msi_wb_arbiter_qos.sv
// Wishbone B3 N-to-1 arbiter with fixed/round-robin selection, bounded ownership,
// a slave-timeout watchdog and grant/timeout status.
module mpsoc_msi_wb_arbiter_qos #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MODE        = 1,
  parameter int MAX_HOLD    = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst,
  input  logic [NUM_MASTERS*AW-1:0]  wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]  wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]     wbm_we_i,
  input  logic [NUM_MASTERS-1:0]     wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]     wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]   wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]   wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]  wbm_dat_o,
  output logic [NUM_MASTERS-1:0]     wbm_ack_o,
  output logic [NUM_MASTERS-1:0]     wbm_err_o,
  output logic [NUM_MASTERS-1:0]     wbm_rty_o,
  output logic [AW-1:0]              wbs_adr_o,
  output logic [DW-1:0]              wbs_dat_o,
  output logic [DW/8-1:0]            wbs_sel_o,
  output logic                       wbs_we_o,
  output logic                       wbs_cyc_o,
  output logic                       wbs_stb_o,
  output logic [2:0]                 wbs_cti_o,
  output logic [1:0]                 wbs_bte_o,
  input  logic [DW-1:0]              wbs_dat_i,
  input  logic                       wbs_ack_i,
  input  logic                       wbs_err_i,
  input  logic                       wbs_rty_i,
  output logic [NUM_MASTERS-1:0]     grant_o,
  output logic                       timeout_o
);

  // state   | meaning
  // S_IDLE  | no owner
  // S_OWN   | owner drives the slave
  // S_YIELD | owner is being forced off (retry on each strobe)
  // S_TOUT  | watchdog error cycle
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_YIELD, S_TOUT} state_t;

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                 r_state, w_state_nxt;
  logic [GW-1:0]          r_grant, r_rr_ptr, w_winner;
  logic [HW-1:0]          r_beat_cnt;
  logic [TW-1:0]          r_wd_cnt;
  logic [NUM_MASTERS-1:0] w_grant_oh;
  logic w_own_cyc, w_own_stb, w_term, w_beat, w_others, w_hold_hit, w_wd_hit;

  assign w_grant_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << r_grant;
  assign w_own_cyc  = wbm_cyc_i[r_grant];
  assign w_own_stb  = wbm_stb_i[r_grant];
  assign w_term     = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_beat     = (r_state == S_OWN) & w_own_cyc & w_own_stb & w_term;
  assign w_others   = |(wbm_cyc_i & ~w_grant_oh);
  assign w_hold_hit = (MAX_HOLD > 0) && w_beat && (r_beat_cnt == HOLD_LAST) && w_others;
  assign w_wd_hit   = (TIMEOUT > 0) && (r_state == S_OWN) && w_own_cyc && w_own_stb &&
                      !w_term && (r_wd_cnt == TO_LAST);

  // Scan starts at the rotating pointer in round-robin mode, at index 0 otherwise.
  always_comb begin : p_winner
    int   idx;
    logic found;
    w_winner = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (MODE == 1) ? ((int'(r_rr_ptr) + i) % NUM_MASTERS) : i;
      if (!found && wbm_cyc_i[idx]) begin
        w_winner = GW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|wbm_cyc_i) w_state_nxt = S_OWN;
      S_OWN: begin
        if (!w_own_cyc)      w_state_nxt = S_IDLE;
        else if (w_hold_hit) w_state_nxt = S_YIELD;
        else if (w_wd_hit)   w_state_nxt = S_TOUT;
      end
      S_YIELD: if (!w_own_cyc) w_state_nxt = S_IDLE;
      S_TOUT:  w_state_nxt = w_own_cyc ? S_OWN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    grant_o   = '0;
    timeout_o = 1'b0;
    case (r_state)
      S_OWN: begin
        wbs_cyc_o          = w_own_cyc;
        wbs_stb_o          = w_own_stb;
        wbm_ack_o[r_grant] = wbs_ack_i;
        wbm_err_o[r_grant] = wbs_err_i;
        wbm_rty_o[r_grant] = wbs_rty_i;
        grant_o            = w_grant_oh;
      end
      S_YIELD: begin
        wbm_rty_o[r_grant] = w_own_stb;
        grant_o            = w_grant_oh;
      end
      S_TOUT: begin
        wbm_err_o[r_grant] = 1'b1;
        timeout_o          = 1'b1;
        grant_o            = w_grant_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_wd_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE && |wbm_cyc_i) begin
        r_grant <= w_winner;
        if (MODE == 1)
          r_rr_ptr <= (int'(w_winner) == NUM_MASTERS - 1) ? '0 : w_winner + 1'b1;
      end
      // Saturates so a lone owner keeps hitting the limit once someone else shows up.
      if (r_state != S_OWN && w_state_nxt == S_OWN)
        r_beat_cnt <= '0;
      else if (w_beat && r_beat_cnt != HOLD_LAST)
        r_beat_cnt <= r_beat_cnt + 1'b1;
      if (TIMEOUT == 0 || r_state != S_OWN || w_state_nxt != r_state ||
          !(w_own_cyc && w_own_stb) || w_term)
        r_wd_cnt <= '0;
      else
        r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign wbs_adr_o = wbm_adr_i[r_grant*AW +: AW];
  assign wbs_dat_o = wbm_dat_i[r_grant*DW +: DW];
  assign wbs_sel_o = wbm_sel_i[r_grant*(DW/8) +: DW/8];
  assign wbs_we_o  = wbm_we_i[r_grant];
  assign wbs_cti_o = wbm_cti_i[r_grant*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[r_grant*2 +: 2];
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

endmodule

// File: tb/tb_mpsoc_msi_wb_arbiter_qos.sv
// Directed bench: a round-robin/hold/timeout instance and a fixed-priority instance
// share master stimulus; each scenario checks one of them against hand-derived values.
module tb_mpsoc_msi_wb_arbiter_qos;

  logic         wb_clk = 1'b0;
  logic         wb_rst = 1'b0;
  logic [127:0] m_adr, m_dat;
  logic [15:0]  m_sel;
  logic [3:0]   m_we, m_cyc, m_stb;
  logic [11:0]  m_cti;
  logic [7:0]   m_bte;
  logic [31:0]  s_dat;
  logic         ack_man, auto_ack, s_err, s_rty;

  logic [127:0] rr_dat_o, fp_dat_o;
  logic [3:0]   rr_ack, rr_err, rr_rty, fp_ack, fp_err, fp_rty;
  logic [31:0]  rr_adr, rr_wdat, fp_adr, fp_wdat;
  logic [3:0]   rr_sel, fp_sel, rr_grant, fp_grant;
  logic         rr_we, fp_we, rr_cyc, rr_stb, fp_cyc, fp_stb, rr_tout, fp_tout;
  logic [2:0]   rr_cti, fp_cti;
  logic [1:0]   rr_bte, fp_bte;
  logic         s_ack;

  assign s_ack = ack_man | (auto_ack & rr_cyc & rr_stb);

  always #5 wb_clk = ~wb_clk;

  mpsoc_msi_wb_arbiter_qos #(.NUM_MASTERS(4), .AW(32), .DW(32), .MODE(1),
                             .MAX_HOLD(4), .TIMEOUT(8)) u_rr (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(rr_dat_o), .wbm_ack_o(rr_ack), .wbm_err_o(rr_err), .wbm_rty_o(rr_rty),
    .wbs_adr_o(rr_adr), .wbs_dat_o(rr_wdat), .wbs_sel_o(rr_sel), .wbs_we_o(rr_we),
    .wbs_cyc_o(rr_cyc), .wbs_stb_o(rr_stb), .wbs_cti_o(rr_cti), .wbs_bte_o(rr_bte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(rr_grant), .timeout_o(rr_tout));

  mpsoc_msi_wb_arbiter_qos #(.NUM_MASTERS(4), .AW(32), .DW(32), .MODE(0),
                             .MAX_HOLD(0), .TIMEOUT(0)) u_fp (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(fp_dat_o), .wbm_ack_o(fp_ack), .wbm_err_o(fp_err), .wbm_rty_o(fp_rty),
    .wbs_adr_o(fp_adr), .wbs_dat_o(fp_wdat), .wbs_sel_o(fp_sel), .wbs_we_o(fp_we),
    .wbs_cyc_o(fp_cyc), .wbs_stb_o(fp_stb), .wbs_cti_o(fp_cti), .wbs_bte_o(fp_bte),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(fp_grant), .timeout_o(fp_tout));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b1;
  endtask

  int         order[$];
  int         cnt[4];
  logic [3:0] got;
  int         acks0;
  logic       seen_rty, seen_gap, got_m2, early;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_adr[i*32 +: 32] = 32'hA000_0000 | i;
      m_dat[i*32 +: 32] = 32'hD000_0000 | i;
    end
    m_sel = 16'h8421; m_we = 4'b0001; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;
    s_dat = 32'h5A5A_1234; ack_man = 1'b0; auto_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // reset state
    #12;
    chk("rst_grant",   rr_grant, 4'b0000);
    chk("rst_cyc_stb", {rr_cyc, rr_stb, fp_cyc}, 3'b000);
    chk("rst_term",    {rr_ack, rr_err, rr_rty, rr_tout}, 13'h0);
    chk("rst_adr",     rr_adr, 32'hA000_0000);
    chk("rst_wdat",    {rr_wdat, rr_sel, rr_we}, {32'hD000_0000, 4'h1, 1'b1});
    chk("dat_bcast",   rr_dat_o, {4{32'h5A5A_1234}});
    @(negedge wb_clk);
    wb_rst = 1'b1;

    // fixed priority: masters 1 and 3 on the same edge
    tick();
    m_cyc = 4'b1010; m_stb = 4'b1010;
    @(negedge wb_clk); chk("fp_idle0", fp_grant, 4'b0000);
    tick(); @(negedge wb_clk);
    chk("fp_grant1", fp_grant, 4'b0010);
    chk("fp_cyc1",   fp_cyc, 1'b1);
    chk("fp_adr1",   fp_adr, 32'hA000_0001);
    tick(); ack_man = 1'b1;
    @(negedge wb_clk); chk("fp_ack1", fp_ack, 4'b0010);
    tick(); ack_man = 1'b0; m_cyc = 4'b1000; m_stb = 4'b1000;
    @(negedge wb_clk); chk("fp_drop_cyc", fp_cyc, 1'b0);
    tick(); @(negedge wb_clk); chk("fp_gap", fp_grant, 4'b0000);
    tick(); @(negedge wb_clk);
    chk("fp_grant3", fp_grant, 4'b1000);
    chk("fp_adr3",   fp_adr, 32'hA000_0003);
    tick(); ack_man = 1'b1;
    @(negedge wb_clk); chk("fp_ack3", fp_ack, 4'b1000);
    tick(); ack_man = 1'b0; m_cyc = '0; m_stb = '0;
    tick(); tick();

    // round-robin fairness, all masters requesting single beats
    do_reset();
    auto_ack = 1'b1; m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int n = 0; n < 1400 && order.size() < 400; n++) begin
      @(negedge wb_clk);
      got = rr_ack;
      for (int i = 0; i < 4; i++)
        if (got[i]) begin
          order.push_back(i);
          cnt[i]++;
        end
      @(posedge wb_clk); #1;
      m_cyc = ~got; m_stb = ~got;
    end
    chk("rr_total", order.size(), 400);
    chk("rr_ord0", order[0], 0);
    chk("rr_ord1", order[1], 1);
    chk("rr_ord2", order[2], 2);
    chk("rr_ord3", order[3], 3);
    chk("rr_ord4", order[4], 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_cnt%0d", i), cnt[i], 100);
    m_cyc = '0; m_stb = '0;
    tick(); tick(); tick();

    // hold limit: master 0 bursts while master 2 waits
    do_reset();
    m_cti[2:0] = 3'b010;
    m_cyc = 4'b0101; m_stb = 4'b0101;
    acks0 = 0; seen_rty = 1'b0; seen_gap = 1'b0; got_m2 = 1'b0;
    for (int n = 0; n < 40 && !got_m2; n++) begin
      @(negedge wb_clk);
      if (rr_ack[0]) begin
        acks0++;
        if (acks0 == 1) chk("hold_cti", rr_cti, 3'b010);
      end
      if (rr_rty[0] && !seen_rty) begin
        seen_rty = 1'b1;
        chk("hold_acks", acks0, 4);
        chk("yield_cyc_low", rr_cyc, 1'b0);
      end
      if (seen_rty && rr_grant == 4'b0000) seen_gap = 1'b1;
      if (rr_grant == 4'b0100) begin
        got_m2 = 1'b1;
        chk("m2_ack", rr_ack, 4'b0100);
      end
      @(posedge wb_clk); #1;
      if (seen_rty) begin m_cyc[0] = 1'b0; m_stb[0] = 1'b0; end
    end
    chk("hold_rty_seen", seen_rty, 1'b1);
    chk("hold_gap",      seen_gap, 1'b1);
    chk("hold_m2_grant", got_m2, 1'b1);
    m_cyc = '0; m_stb = '0; m_cti = '0;
    tick(); tick(); tick();

    // watchdog: slave never answers master 1
    auto_ack = 1'b0;
    m_cyc = 4'b0010; m_stb = 4'b0010;
    early = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick(); @(negedge wb_clk);
      if (rr_err != 0 || rr_tout) early = 1'b1;
    end
    chk("tout_not_early", early, 1'b0);
    tick(); ack_man = 1'b1;
    @(negedge wb_clk);
    chk("tout_err",      rr_err, 4'b0010);
    chk("tout_pulse",    rr_tout, 1'b1);
    chk("tout_cyc_low",  rr_cyc, 1'b0);
    chk("tout_late_ack", rr_ack, 4'b0000);
    tick(); ack_man = 1'b0;
    @(negedge wb_clk);
    chk("tout_one_cycle", {rr_tout, rr_err}, 5'b0);
    chk("tout_back_own",  {rr_grant, rr_cyc}, {4'b0010, 1'b1});
    m_cyc = '0; m_stb = '0;
    tick(); tick(); tick();

    // asynchronous reset during beat 3 of a burst from master 2
    auto_ack = 1'b1;
    m_cyc = 4'b0100; m_stb = 4'b0100;
    tick(); tick(); tick();
    @(negedge wb_clk);
    chk("beat3_ack", rr_ack, 4'b0100);
    #2 wb_rst = 1'b0;
    #1;
    chk("arst_cyc",   {rr_cyc, rr_stb}, 2'b00);
    chk("arst_term",  {rr_ack, rr_err, rr_rty, rr_tout}, 13'h0);
    chk("arst_grant", rr_grant, 4'b0000);
    chk("arst_adr",   rr_adr, 32'hA000_0000);
    m_cyc = 4'b1111; m_stb = 4'b1111;
    @(negedge wb_clk);
    wb_rst = 1'b1;
    tick(); @(negedge wb_clk);
    chk("post_rst_ptr0", rr_grant, 4'b0001);
    m_cyc = '0; m_stb = '0; auto_ack = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
